// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing definitions: 640x480@60 defaults, phase encodings,
// sync polarity values and the phase-advance helper used by both phase FSMs.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  typedef struct packed {
    phase_t h;
    phase_t v;
  } phase_dbg_t;

  // Phase after the counter advances from cnt; a phase ends on its last count.
  function automatic phase_t phase_step(phase_t ph, int cnt, int active,
                                        int fp, int sync, int total);
    phase_t nxt;
    nxt = ph;
    case (ph)
      PH_ACTIVE: if (cnt == active - 1)             nxt = PH_FP;
      PH_FP:     if (cnt == active + fp - 1)        nxt = PH_SYNC;
      PH_SYNC:   if (cnt == active + fp + sync - 1) nxt = PH_BP;
      PH_BP:     if (cnt == total - 1)              nxt = PH_ACTIVE;
      default:                                      nxt = PH_ACTIVE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Clock-enable divider: tick is high for one clk out of every CLK_DIV clks.
module pix_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  div_cnt <= '0;
    else if (div_cnt == LAST) div_cnt <= '0;
    else                      div_cnt <= div_cnt + DW'(1);
  end

  // With CLK_DIV=1, LAST is 0 and the counter never leaves it: tick every clk.
  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: h/v counters with phase FSMs; every output is
// registered from next-state values so coordinates, enables and syncs align.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int   CLK_DIV  = 2,
  parameter int   CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pix_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             dena,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start,
  output phase_dbg_t       phase_dbg
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic             tick;
  logic [CNT_W-1:0] h, v, h_nxt, v_nxt;
  logic             h_wrap, v_wrap;
  phase_t           h_ph, v_ph, h_ph_nxt, v_ph_nxt;

  pix_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    h_nxt    = h;
    v_nxt    = v;
    h_wrap   = 1'b0;
    v_wrap   = 1'b0;
    h_ph_nxt = h_ph;
    v_ph_nxt = v_ph;
    if (tick) begin
      h_ph_nxt = phase_step(h_ph, 32'(h), H_ACTIVE, H_FP, H_SYNC, H_TOTAL);
      if (h == H_LAST) begin
        h_nxt    = '0;
        h_wrap   = 1'b1;
        v_ph_nxt = phase_step(v_ph, 32'(v), V_ACTIVE, V_FP, V_SYNC, V_TOTAL);
        if (v == V_LAST) begin
          v_nxt  = '0;
          v_wrap = 1'b1;
        end else begin
          v_nxt = v + CNT_W'(1);
        end
      end else begin
        h_nxt = h + CNT_W'(1);
      end
    end
  end

  // Counters start on the last position so the first tick lands on (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h    <= H_LAST;
      v    <= V_LAST;
      h_ph <= PH_BP;
      v_ph <= PH_BP;
    end else begin
      h    <= h_nxt;
      v    <= v_nxt;
      h_ph <= h_ph_nxt;
      v_ph <= v_ph_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_tick    <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      dena        <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick;
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
      if (tick) begin
        pixel_x <= h_nxt;
        pixel_y <= v_nxt;
        dena    <= (h_ph_nxt == PH_ACTIVE) && (v_ph_nxt == PH_ACTIVE);
        hsync   <= (h_ph_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync   <= (v_ph_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  assign phase_dbg = '{h: h_ph, v: v_ph};

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (small active-low /2, small
// active-high /1, default 640x480 /2) checked against a tick-index model.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic       tk, hs, vs, de, ls, fs;
    logic [9:0] x, y;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Active clock edges seen since the last reset release.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int tests = 0;
  int fails = 0;

  logic a_tk, a_hs, a_vs, a_de, a_ls, a_fs;
  logic b_tk, b_hs, b_vs, b_de, b_ls, b_fs;
  logic c_tk, c_hs, c_vs, c_de, c_ls, c_fs;
  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  phase_dbg_t a_dbg, b_dbg, c_dbg;
  obs_t obs_a, obs_b, obs_c;

  vga_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                 .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                 .SYNC_POL(1'b0), .CLK_DIV(2), .CNT_W(10)) dut_a (
    .clk(clk), .rst(rst), .pix_tick(a_tk), .hsync(a_hs), .vsync(a_vs),
    .dena(a_de), .pixel_x(a_x), .pixel_y(a_y), .line_start(a_ls),
    .frame_start(a_fs), .phase_dbg(a_dbg));

  vga_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                 .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                 .SYNC_POL(1'b1), .CLK_DIV(1), .CNT_W(10)) dut_b (
    .clk(clk), .rst(rst), .pix_tick(b_tk), .hsync(b_hs), .vsync(b_vs),
    .dena(b_de), .pixel_x(b_x), .pixel_y(b_y), .line_start(b_ls),
    .frame_start(b_fs), .phase_dbg(b_dbg));

  vga_sync_gen #(.CLK_DIV(2)) dut_c (
    .clk(clk), .rst(rst), .pix_tick(c_tk), .hsync(c_hs), .vsync(c_vs),
    .dena(c_de), .pixel_x(c_x), .pixel_y(c_y), .line_start(c_ls),
    .frame_start(c_fs), .phase_dbg(c_dbg));

  assign obs_a = {a_tk, a_hs, a_vs, a_de, a_ls, a_fs, a_x, a_y};
  assign obs_b = {b_tk, b_hs, b_vs, b_de, b_ls, b_fs, b_x, b_y};
  assign obs_c = {c_tk, c_hs, c_vs, c_de, c_ls, c_fs, c_x, c_y};

  // Reference: after c edges, k = c/d ticks have occurred; tick k sits at raster
  // position k-1 (row-major), and tick edges are those with c divisible by d.
  function automatic obs_t model(int ha, int hf, int hsw, int hb, int va, int vf,
                                 int vsw, int vb, logic pol, int d, int c);
    obs_t o;
    int ht, vt, k, p, x, y;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    k  = c / d;
    o.tk = 1'b0; o.hs = ~pol; o.vs = ~pol; o.de = 1'b0;
    o.ls = 1'b0; o.fs = 1'b0; o.x = '0; o.y = '0;
    if (k == 0) return o;
    p = (k - 1) % (ht * vt);
    x = p % ht;
    y = p / ht;
    o.tk = (c % d == 0);
    o.x  = 10'(x);
    o.y  = 10'(y);
    o.de = (x < ha) && (y < va);
    o.hs = (x >= ha + hf && x < ha + hf + hsw) ? pol : ~pol;
    o.vs = (y >= va + vf && y < va + vf + vsw) ? pol : ~pol;
    o.ls = o.tk && (x == 0);
    o.fs = o.ls && (y == 0);
    return o;
  endfunction

  function automatic obs_t exp_a(int c);
    return model(8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 2, c);
  endfunction
  function automatic obs_t exp_b(int c);
    return model(8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1, c);
  endfunction
  function automatic obs_t exp_c(int c);
    return model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 2, c);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (obs_a !== exp_a(0)) begin fails++; $display("FAIL reset_a got=%h exp=%h", obs_a, exp_a(0)); end
    tests++; if (obs_b !== exp_b(0)) begin fails++; $display("FAIL reset_b got=%h exp=%h", obs_b, exp_b(0)); end
    tests++; if (obs_c !== exp_c(0)) begin fails++; $display("FAIL reset_c got=%h exp=%h", obs_c, exp_c(0)); end
    tests++;
    if ({a_dbg, b_dbg, c_dbg} !== {3{PH_BP, PH_BP}}) begin
      fails++; $display("FAIL reset_phase got=%h exp=%h", {a_dbg, b_dbg, c_dbg}, {3{PH_BP, PH_BP}});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (obs_a !== exp_a(cyc)) begin fails++; $display("FAIL release_clk1 got=%h exp=%h", obs_a, exp_a(cyc)); end
    @(negedge clk);
    tests++;
    if ({a_tk, a_fs, a_ls, a_de, a_x, a_y} !== {4'b1111, 20'd0}) begin
      fails++; $display("FAIL first_tick got=%b exp=%b", {a_tk, a_fs, a_ls, a_de, a_x, a_y}, {4'b1111, 20'd0});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests++; if (a_tk !== (i % 2 == 1)) begin fails++; $display("FAIL tick_cadence i=%0d got=%b exp=%b", i, a_tk, (i % 2 == 1)); end
    end
  endtask

  task automatic test_line();
    int found, de_cnt, hs_cnt, hs_min, hs_max, t;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (a_ls) found = 1;
    end
    tests++; if (found == 0) begin fails++; $display("FAIL line_wait got=timeout exp=line_start"); end
    de_cnt = 0; hs_cnt = 0; hs_min = 99; hs_max = -1; t = 0;
    while (t < 15 && found != 0) begin
      tests++; if (obs_a !== exp_a(cyc)) begin fails++; $display("FAIL line_model cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a(cyc)); end
      if (a_tk) begin
        if (a_de) de_cnt++;
        if (!a_hs) begin
          hs_cnt++;
          if (int'(a_x) < hs_min) hs_min = int'(a_x);
          if (int'(a_x) > hs_max) hs_max = int'(a_x);
        end
        t++;
      end
      @(negedge clk);
      if (!a_tk) @(negedge clk);
    end
    tests++; if (!(a_ls === 1'b1 && a_x === 10'd0)) begin fails++; $display("FAIL line_restart got=%b/%0d exp=1/0", a_ls, a_x); end
    tests++; if (de_cnt !== 8) begin fails++; $display("FAIL line_dena_ticks got=%0d exp=8", de_cnt); end
    tests++;
    if ({hs_cnt, hs_min, hs_max} !== {32'd3, 32'd10, 32'd12}) begin
      fails++; $display("FAIL line_hsync got=%0d [%0d,%0d] exp=3 [10,12]", hs_cnt, hs_min, hs_max);
    end
  endtask

  task automatic test_frame();
    int found, start;
    logic [7:0] vs_lines, de_lines;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(negedge clk);
      if (a_fs) found = 1;
    end
    tests++; if (found == 0) begin fails++; $display("FAIL frame_wait got=timeout exp=frame_start"); end
    start = cyc; vs_lines = '0; de_lines = '0;
    for (int i = 0; i < 240; i++) begin
      tests++; if (obs_a !== exp_a(cyc)) begin fails++; $display("FAIL frame_model cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a(cyc)); end
      if (a_tk && a_y < 10'd8) begin
        if (!a_vs) vs_lines[a_y[2:0]] = 1'b1;
        if (a_de)  de_lines[a_y[2:0]] = 1'b1;
        tests++;
        if (a_dbg.h !== ((a_x < 8) ? PH_ACTIVE : (a_x < 10) ? PH_FP : (a_x < 13) ? PH_SYNC : PH_BP)) begin
          fails++; $display("FAIL frame_hphase x=%0d got=%0d", a_x, a_dbg.h);
        end
      end
      @(negedge clk);
    end
    tests++; if (!(a_fs === 1'b1 && cyc - start == 240)) begin fails++; $display("FAIL frame_period got=%b@%0d exp=1@240", a_fs, cyc - start); end
    tests++; if (vs_lines !== 8'b0110_0000) begin fails++; $display("FAIL frame_vsync_lines got=%b exp=01100000", vs_lines); end
    tests++; if (de_lines !== 8'b0000_1111) begin fails++; $display("FAIL frame_dena_lines got=%b exp=00001111", de_lines); end
  endtask

  task automatic test_mid_reset();
    int found;
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clk);
      tests++; if (obs_a !== exp_a(cyc)) begin fails++; $display("FAIL mid_pre cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a(cyc)); end
      if (a_tk && a_x == 10'd5 && a_y == 10'd2) found = 1;
    end
    tests++; if (found == 0) begin fails++; $display("FAIL mid_wait got=timeout exp=x5y2"); end
    #1 rst = 1'b1;
    #1;
    tests++; if (obs_a !== exp_a(0)) begin fails++; $display("FAIL mid_async_a got=%h exp=%h", obs_a, exp_a(0)); end
    tests++; if (obs_b !== exp_b(0)) begin fails++; $display("FAIL mid_async_b got=%h exp=%h", obs_b, exp_b(0)); end
    tests++; if (obs_c !== exp_c(0)) begin fails++; $display("FAIL mid_async_c got=%h exp=%h", obs_c, exp_c(0)); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tests++; if (obs_a !== exp_a(cyc)) begin fails++; $display("FAIL mid_restart cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a(cyc)); end
      if (cyc == 2) begin
        tests++;
        if ({a_fs, a_ls, a_de, a_x, a_y} !== {3'b111, 20'd0}) begin
          fails++; $display("FAIL mid_first_tick got=%b exp=%b", {a_fs, a_ls, a_de, a_x, a_y}, {3'b111, 20'd0});
        end
      end
    end
  endtask

  task automatic test_pol_div1();
    int found, tk_low, hs_hi, vs_hi;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (b_fs) found = 1;
    end
    tests++; if (found == 0) begin fails++; $display("FAIL pol_wait got=timeout exp=frame_start"); end
    tk_low = 0; hs_hi = 0; vs_hi = 0;
    for (int i = 0; i < 240; i++) begin
      tests++; if (obs_b !== exp_b(cyc)) begin fails++; $display("FAIL pol_model cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b(cyc)); end
      if (!b_tk) tk_low++;
      if (b_hs)  hs_hi++;
      if (b_vs)  vs_hi++;
      @(negedge clk);
    end
    tests++; if (tk_low !== 0) begin fails++; $display("FAIL pol_tick_const got=%0d exp=0", tk_low); end
    tests++; if (hs_hi !== 48) begin fails++; $display("FAIL pol_hsync_high got=%0d exp=48", hs_hi); end
    tests++; if (vs_hi !== 60) begin fails++; $display("FAIL pol_vsync_high got=%0d exp=60", vs_hi); end
  endtask

  task automatic test_default();
    int max_x, last_ls, period;
    max_x = 0; last_ls = -1; period = 0;
    for (int i = 0; i < 3400; i++) begin
      @(negedge clk);
      tests++; if (obs_c !== exp_c(cyc)) begin fails++; $display("FAIL dflt_model cyc=%0d got=%h exp=%h", cyc, obs_c, exp_c(cyc)); end
      if (int'(c_x) > max_x) max_x = int'(c_x);
      if (c_ls) begin
        if (last_ls >= 0) period = cyc - last_ls;
        last_ls = cyc;
      end
    end
    tests++; if (max_x !== 799) begin fails++; $display("FAIL dflt_max_x got=%0d exp=799", max_x); end
    tests++; if (period !== 1600) begin fails++; $display("FAIL dflt_line_period got=%0d exp=1600", period); end
  endtask

  task automatic test_random_reset();
    int run, hold;
    for (int r = 0; r < 4; r++) begin
      run = int'($urandom_range(1, 400));
      for (int i = 0; i < run; i++) begin
        @(negedge clk);
        tests++; if (obs_a !== exp_a(cyc)) begin fails++; $display("FAIL rnd_a cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a(cyc)); end
        tests++; if (obs_b !== exp_b(cyc)) begin fails++; $display("FAIL rnd_b cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b(cyc)); end
      end
      hold = int'($urandom_range(1, 3));
      #1 rst = 1'b1;
      #1;
      tests++; if (obs_b !== exp_b(0)) begin fails++; $display("FAIL rnd_async_b got=%h exp=%h", obs_b, exp_b(0)); end
      repeat (hold) @(negedge clk);
      tests++; if (obs_a !== exp_a(0)) begin fails++; $display("FAIL rnd_hold_a got=%h exp=%h", obs_a, exp_a(0)); end
      rst = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    test_pol_div1();
    test_default();
    test_random_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
